// File: rtl/tetris_seq_ctrl.sv
// Tetris game sequencer: state codes, one move per step, gravity timer, score/lines/level.
// Latency: every output registered, reacts the cycle after its input is sampled; no backpressure, button requests queue one deep each.
module tetris_seq_ctrl #(
  parameter int DROP_TICKS      = 24,
  parameter int DROP_STEP       = 2,
  parameter int MIN_TICKS       = 4,
  parameter int LINES_PER_LEVEL = 10,
  parameter int CLEAR_TIMEOUT   = 64
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        touched,
  input  logic        spawn_blocked,
  input  logic        clear_done,
  input  logic [2:0]  rows_cleared,
  output logic [3:0]  state,
  output logic [1:0]  move,
  output logic        move_valid,
  output logic [15:0] score,
  output logic [7:0]  lines,
  output logic [3:0]  level,
  output logic        fault
);

  typedef enum logic [3:0] {
    ST_GEN      = 4'd0,
    ST_MOVE     = 4'd1,
    ST_LAND     = 4'd2,
    ST_CLEAR    = 4'd3,
    ST_NEWBOARD = 4'd4,
    ST_GAMEOVER = 4'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  move_q, move_d;
  logic        move_vld_q, move_vld_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  lines_q, lines_d;
  logic [3:0]  level_q, level_d;
  logic        fault_q, fault_d;
  logic [7:0]  grav_q, grav_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]  sub_q, sub_d;
  logic        pend_left_q, pend_left_d;
  logic        pend_right_q, pend_right_d;
  logic        pend_rot_q, pend_rot_d;

  logic [7:0]  prod;
  logic [8:0]  floor_sum;
  logic [7:0]  period;
  logic [2:0]  rows_n;
  logic [7:0]  base_pts;
  logic [7:0]  add_pts;
  logic [16:0] score_sum;
  logic [8:0]  lines_sum;
  logic [7:0]  sub_sum;
  logic        btn_ok;

  // Compare before subtracting so high levels clamp to MIN_TICKS instead of wrapping.
  assign prod      = 8'(level_q) * 8'(DROP_STEP);
  assign floor_sum = {1'b0, prod} + 9'(MIN_TICKS);
  assign period    = (floor_sum >= 9'(DROP_TICKS)) ? 8'(MIN_TICKS) : 8'(DROP_TICKS) - prod;

  assign rows_n    = (rows_cleared > 3'd4) ? 3'd4 : rows_cleared;
  assign add_pts   = base_pts * (8'(level_q) + 8'd1);
  assign score_sum = {1'b0, score_q} + 17'(add_pts);
  assign lines_sum = {1'b0, lines_q} + 9'(rows_n);
  assign sub_sum   = sub_q + 8'(rows_n);
  assign btn_ok    = (state_q != ST_GAMEOVER);

  always_comb begin
    base_pts = 8'd0;
    case (rows_n)
      3'd1:    base_pts = 8'd1;
      3'd2:    base_pts = 8'd3;
      3'd3:    base_pts = 8'd5;
      3'd4:    base_pts = 8'd8;
      default: base_pts = 8'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    move_d       = move_q;
    move_vld_d   = 1'b0;
    score_d      = score_q;
    lines_d      = lines_q;
    level_d      = level_q;
    fault_d      = fault_q;
    grav_d       = grav_q;
    clr_cnt_d    = clr_cnt_q;
    sub_d        = sub_q;
    // A pulse landing on the cycle its flag is consumed re-arms the flag.
    pend_left_d  = pend_left_q  | (btn_left   & btn_ok);
    pend_right_d = pend_right_q | (btn_right  & btn_ok);
    pend_rot_d   = pend_rot_q   | (btn_rotate & btn_ok);

    case (state_q)
      ST_NEWBOARD: state_d = ST_GEN;
      ST_GEN: begin
        if (spawn_blocked) begin
          state_d = ST_GAMEOVER;
        end else begin
          state_d = ST_MOVE;
          grav_d  = period;
        end
      end
      ST_MOVE: begin
        if (touched) begin
          state_d      = ST_LAND;
          pend_left_d  = 1'b0;
          pend_right_d = 1'b0;
          pend_rot_d   = 1'b0;
        end else if (grav_q == 8'd1) begin
          move_d     = 2'd3;
          move_vld_d = 1'b1;
          grav_d     = period;
        end else if (pend_rot_q) begin
          move_d     = 2'd2;
          move_vld_d = 1'b1;
          pend_rot_d = btn_rotate;
        end else if (pend_left_q) begin
          move_d      = 2'd0;
          move_vld_d  = 1'b1;
          pend_left_d = btn_left;
        end else if (pend_right_q) begin
          move_d       = 2'd1;
          move_vld_d   = 1'b1;
          pend_right_d = btn_right;
        end else begin
          grav_d = grav_q - 8'd1;
        end
      end
      ST_LAND: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = 8'd0;
      end
      ST_CLEAR: begin
        if (clear_done) begin
          state_d = ST_GEN;
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          lines_d = lines_sum[8] ? 8'hFF : lines_sum[7:0];
          if (sub_sum >= 8'(LINES_PER_LEVEL)) begin
            sub_d   = sub_sum - 8'(LINES_PER_LEVEL);
            level_d = (level_q == 4'hF) ? level_q : level_q + 4'd1;
          end else begin
            sub_d = sub_sum;
          end
        end else if (clr_cnt_q == 8'(CLEAR_TIMEOUT - 1)) begin
          state_d = ST_GEN;
          fault_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end
      ST_GAMEOVER: begin
        if (start) begin
          state_d = ST_NEWBOARD;
          score_d = 16'd0;
          lines_d = 8'd0;
          level_d = 4'd0;
          fault_d = 1'b0;
          sub_d   = 8'd0;
        end
      end
      default: state_d = ST_NEWBOARD;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q      <= ST_NEWBOARD;
      move_q       <= 2'd3;
      move_vld_q   <= 1'b0;
      score_q      <= 16'd0;
      lines_q      <= 8'd0;
      level_q      <= 4'd0;
      fault_q      <= 1'b0;
      grav_q       <= 8'd0;
      clr_cnt_q    <= 8'd0;
      sub_q        <= 8'd0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      pend_rot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_q       <= move_d;
      move_vld_q   <= move_vld_d;
      score_q      <= score_d;
      lines_q      <= lines_d;
      level_q      <= level_d;
      fault_q      <= fault_d;
      grav_q       <= grav_d;
      clr_cnt_q    <= clr_cnt_d;
      sub_q        <= sub_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_rot_q   <= pend_rot_d;
    end
  end

  assign state      = state_q;
  assign move       = move_q;
  assign move_valid = move_vld_q;
  assign score      = score_q;
  assign lines      = lines_q;
  assign level      = level_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_tetris_seq_ctrl.sv
// Directed bench for tetris_seq_ctrl; expected values hand-computed from the default parameters.
module tb_tetris_seq_ctrl;

  logic        clka = 1'b0;
  logic        restart_n = 1'b0;
  logic        start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_rotate = 1'b0;
  logic        touched = 1'b0;
  logic        spawn_blocked = 1'b0;
  logic        clear_done = 1'b0;
  logic [2:0]  rows_cleared = 3'd0;
  logic [3:0]  state;
  logic [1:0]  move;
  logic        move_valid;
  logic [15:0] score;
  logic [7:0]  lines;
  logic [3:0]  level;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  tetris_seq_ctrl dut (
    .clka(clka), .restart_n(restart_n), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .touched(touched), .spawn_blocked(spawn_blocked), .clear_done(clear_done),
    .rows_cleared(rows_cleared), .state(state), .move(move), .move_valid(move_valid),
    .score(score), .lines(lines), .level(level), .fault(fault)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Cycles until the next move_valid strobe; -1 if none within max.
  task automatic wait_mv(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (move_valid) begin
        n = i;
        break;
      end
    end
  endtask

  // From MOVE: land, clear `rows`, return with MOVE visible again.
  task automatic land_and_clear(input logic [2:0] rows);
    touched = 1'b1;
    tick();
    touched = 1'b0;
    tick();
    clear_done = 1'b1;
    rows_cleared = rows;
    tick();
    clear_done = 1'b0;
    rows_cleared = 3'd0;
    tick();
  endtask

  initial begin
    #12;
    chk("rst_state", state, 4);
    chk("rst_mv", move_valid, 0);
    chk("rst_move", move, 3);
    chk("rst_score", score, 0);
    chk("rst_lines", lines, 0);
    chk("rst_level", level, 0);
    chk("rst_fault", fault, 0);
    tick();
    restart_n = 1'b1;
    chk("nb_state", state, 4);
    tick();
    chk("gen_state", state, 0);
    tick();
    chk("move_state", state, 1);
    wait_mv(40, cyc);
    chk("grav_first_cyc", cyc, 24);
    chk("grav_first_move", move, 3);

    // left + rotate together, then a repeat left while pending
    btn_left = 1'b1;
    btn_rotate = 1'b1;
    tick();
    btn_rotate = 1'b0;
    chk("btn_lat_mv", move_valid, 0);
    tick();
    btn_left = 1'b0;
    chk("rot_mv", move_valid, 1);
    chk("rot_move", move, 2);
    tick();
    chk("left_mv", move_valid, 1);
    chk("left_move", move, 0);
    tick();
    chk("no_2nd_left_a", move_valid, 0);
    tick();
    chk("no_2nd_left_b", move_valid, 0);
    wait_mv(40, cyc);
    chk("grav_resync_move", move, 3);

    // right pending exactly when gravity expires
    repeat (22) tick();
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    chk("pre_grav_mv", move_valid, 0);
    tick();
    chk("grav_win_mv", move_valid, 1);
    chk("grav_win_move", move, 3);
    tick();
    chk("right_after_mv", move_valid, 1);
    chk("right_after_move", move, 1);

    // touched together with gravity expiry
    wait_mv(40, cyc);
    chk("grav_resync2", move, 3);
    repeat (23) tick();
    touched = 1'b1;
    tick();
    touched = 1'b0;
    chk("touch_mv", move_valid, 0);
    chk("touch_state", state, 2);
    tick();
    chk("clear_state", state, 3);
    clear_done = 1'b1;
    rows_cleared = 3'd4;
    tick();
    clear_done = 1'b0;
    chk("clr1_state", state, 0);
    chk("clr1_score", score, 8);
    chk("clr1_lines", lines, 4);
    tick();
    chk("clr1_move_state", state, 1);

    // clear_done outside CLEAR is ignored
    clear_done = 1'b1;
    rows_cleared = 3'd4;
    tick();
    clear_done = 1'b0;
    rows_cleared = 3'd0;
    chk("ign_done_score", score, 8);

    land_and_clear(3'd4);
    chk("clr2_score", score, 16);
    chk("clr2_lines", lines, 8);
    land_and_clear(3'd3);
    chk("clr3_score", score, 21);
    chk("clr3_level", level, 1);
    land_and_clear(3'd4);
    chk("lvl1_tetris_score", score, 37);
    chk("lvl1_tetris_lines", lines, 15);
    land_and_clear(3'd7);
    chk("rows_clamp_score", score, 53);
    chk("rows_clamp_lines", lines, 19);
    chk("rows_clamp_level", level, 1);
    wait_mv(40, cyc);
    chk("grav_lvl1_cyc", cyc, 22);

    // CLEAR timeout
    touched = 1'b1;
    tick();
    touched = 1'b0;
    tick();
    chk("to_clear_state", state, 3);
    repeat (63) tick();
    chk("to_before_state", state, 3);
    chk("to_before_fault", fault, 0);
    tick();
    chk("to_state", state, 0);
    chk("to_fault", fault, 1);
    chk("to_score", score, 53);

    spawn_blocked = 1'b1;
    tick();
    spawn_blocked = 1'b0;
    chk("go_state", state, 5);
    btn_left = 1'b1;
    tick();
    btn_left = 1'b0;
    tick();
    chk("go_hold_state", state, 5);
    chk("go_hold_mv", move_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", state, 4);
    chk("start_score", score, 0);
    chk("start_lines", lines, 0);
    chk("start_level", level, 0);
    chk("start_fault", fault, 0);
    tick();
    tick();
    chk("restart_move_state", state, 1);
    wait_mv(40, cyc);
    chk("go_btn_dropped_cyc", cyc, 24);
    chk("go_btn_dropped_move", move, 3);

    // asynchronous reset mid-MOVE with pending buttons
    land_and_clear(3'd1);
    chk("pre_rst_score", score, 1);
    btn_left = 1'b1;
    btn_rotate = 1'b1;
    tick();
    btn_left = 1'b0;
    btn_rotate = 1'b0;
    restart_n = 1'b0;
    #1;
    chk("arst_state", state, 4);
    chk("arst_score", score, 0);
    chk("arst_lines", lines, 0);
    chk("arst_mv", move_valid, 0);
    chk("arst_move", move, 3);
    tick();
    tick();
    restart_n = 1'b1;
    tick();
    tick();
    chk("arst_move_state", state, 1);
    wait_mv(40, cyc);
    chk("arst_first_cyc", cyc, 24);
    chk("arst_first_move", move, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
